// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory and mem_port_arbiter.
// master is the arbiter's view; slave is the view of the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [1:0]    gnt;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, ack1, rdata, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, ack1, rdata, gnt, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the core's single unified memory: grants one access at a time,
// strobes the fixed-latency memory once, captures read data and returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);
  localparam logic [7:0] LAT_CNT = 8'(LAT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    cnt;
  logic          last_gnt;
  logic [1:0]    gnt_q;
  logic          en_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          any_req;
  logic          tie;
  logic          pick1;

  // On a tie the port that did not win the previous tie is served; a lone request always wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    tie     = bus.req0 & bus.req1;
    pick1   = bus.req1 & (~bus.req0 | ~last_gnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (cnt == 8'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched once at the grant edge so later requester activity is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 8'd0;
      last_gnt <= 1'b1;
      gnt_q    <= 2'b00;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= pick1 ? 2'b10 : 2'b01;
            we_q    <= pick1 ? bus.we1 : bus.we0;
            addr_q  <= pick1 ? bus.addr1 : bus.addr0;
            wdata_q <= pick1 ? bus.wdata1 : bus.wdata0;
            cnt     <= LAT_CNT;
            en_q    <= 1'b1;
            if (tie) last_gnt <= pick1;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          gnt_q <= 2'b00;
          we_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ack0      = (state == DONE) & gnt_q[0];
    bus.ack1      = (state == DONE) & gnt_q[1];
    bus.busy      = (state != IDLE);
    bus.gnt       = gnt_q;
    bus.rdata     = rdata_q;
    bus.mem_en    = en_q;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=2 and LAT=1) share one stimulus set and a
// behavioural memory; directed tables, corner-case sequences and a randomized model check.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;
  bit          sel = 1'b0;
  int          cyc = 0;
  int          en_cyc = -1000;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] devmem [256];
  logic [31:0] model_mem [256];

  logic        o_ack0, o_ack1, o_busy, o_en, o_we;
  logic [1:0]  o_gnt;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [102:0] obs_vec;

  mem_port_arbiter_if #(.AW(32), .DW(32)) if2 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) if1 ();

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.master));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  assign if2.req0 = req0;  assign if2.we0 = we0;  assign if2.addr0 = addr0;  assign if2.wdata0 = wdata0;
  assign if2.req1 = req1;  assign if2.we1 = we1;  assign if2.addr1 = addr1;  assign if2.wdata1 = wdata1;
  assign if2.mem_rdata = mem_rdata;
  assign if1.req0 = req0;  assign if1.we0 = we0;  assign if1.addr0 = addr0;  assign if1.wdata0 = wdata0;
  assign if1.req1 = req1;  assign if1.we1 = we1;  assign if1.addr1 = addr1;  assign if1.wdata1 = wdata1;
  assign if1.mem_rdata = mem_rdata;

  always #5 clk = ~clk;

  always_comb begin
    o_ack0  = sel ? if1.ack0      : if2.ack0;
    o_ack1  = sel ? if1.ack1      : if2.ack1;
    o_busy  = sel ? if1.busy      : if2.busy;
    o_en    = sel ? if1.mem_en    : if2.mem_en;
    o_we    = sel ? if1.mem_we    : if2.mem_we;
    o_gnt   = sel ? if1.gnt       : if2.gnt;
    o_addr  = sel ? if1.mem_addr  : if2.mem_addr;
    o_wdata = sel ? if1.mem_wdata : if2.mem_wdata;
    o_rdata = sel ? if1.rdata     : if2.rdata;
    obs_vec = {o_ack0, o_ack1, o_gnt, o_busy, o_en, o_we, o_addr, o_wdata, o_rdata};
  end

  typedef struct {
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        ack0, ack1;
    logic [1:0]  gnt;
    logic        busy, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, rdata;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t row(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic k0, input logic k1, input logic [1:0] g, input logic b,
                               input logic en, input logic mwe, input logic [31:0] ma,
                               input logic [31:0] mwd, input logic [31:0] rd);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.ack0 = k0; v.ack1 = k1; v.gnt = g; v.busy = b; v.mem_en = en; v.mem_we = mwe;
    v.mem_addr = ma; v.mem_wdata = mwd; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory returns valid data only in the cycle LAT after the strobe; garbage otherwise.
  task automatic dev_tick();
    int lat;
    lat = sel ? 1 : 2;
    if (o_en) begin
      en_cyc = cyc;
      if (o_we) devmem[o_addr[7:0]] = o_wdata;
    end
    if (cyc == en_cyc + lat) mem_rdata = devmem[o_addr[7:0]];
    else                     mem_rdata = 32'hBAD0_0000 | 32'(cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    dev_tick();
  endtask

  task automatic do_reset();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    en_cyc = -1000;
  endtask

  task automatic run_tab(input string nm);
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      chk($sformatf("%s_row%0d", nm, k), 128'(obs_vec),
          128'({tab[k].ack0, tab[k].ack1, tab[k].gnt, tab[k].busy, tab[k].mem_en, tab[k].mem_we,
                tab[k].mem_addr, tab[k].mem_wdata, tab[k].rdata}));
      req0 = tab[k].req0; we0 = tab[k].we0; addr0 = tab[k].addr0; wdata0 = tab[k].wdata0;
      req1 = tab[k].req1; we1 = tab[k].we1; addr1 = tab[k].addr1; wdata1 = tab[k].wdata1;
    end
  endtask

  // Reference: a granted access sampled at cycle t0 occupies t0+1..t0+LAT+2, strobe at t0+1,
  // ack at t0+LAT+2; ties alternate, a lone request always wins.
  task automatic rand_run(input int n, input string nm);
    int          lat, t0, ph;
    bit          act, last, mport;
    logic        mwe, k0, k1;
    logic [31:0] ma_h, mw_h, mrd;
    logic [102:0] exp;
    lat = sel ? 1 : 2;
    for (int i = 0; i < 256; i++) begin
      devmem[i] = $urandom;
      model_mem[i] = devmem[i];
    end
    do_reset();
    act = 1'b0; last = 1'b1; mport = 1'b0; mwe = 1'b0; t0 = 0;
    ma_h = '0; mw_h = '0; mrd = '0;
    for (int c = 0; c < n; c++) begin
      tick();
      ph = act ? cyc - t0 : 0;
      if (act && ph >= 1)
        exp = {(ph == lat + 2) && !mport, (ph == lat + 2) && mport, mport ? 2'b10 : 2'b01,
               1'b1, ph == 1, mwe, ma_h, mw_h, mrd};
      else
        exp = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ma_h, mw_h, mrd};
      chk(nm, 128'(obs_vec), 128'(exp));
      if (o_ack0 && o_ack1) begin
        checks++; errors++;
        $display("FAIL %s_both_ack got 11 want at most one", nm);
      end
      k0 = act && (ph == lat + 2) && !mport;
      k1 = act && (ph == lat + 2) && mport;
      if (act && ph == 1 && mwe) model_mem[ma_h[7:0]] = mw_h;
      if (act && ph == lat + 1 && !mwe) mrd = model_mem[ma_h[7:0]];
      if (req0) begin
        if (k0) req0 = ($urandom_range(1, 0) == 1);
        else if ($urandom_range(15, 0) == 0) req0 = 1'b0;
      end else req0 = ($urandom_range(2, 0) == 0);
      if (req1) begin
        if (k1) req1 = ($urandom_range(1, 0) == 1);
        else if ($urandom_range(15, 0) == 0) req1 = 1'b0;
      end else req1 = ($urandom_range(2, 0) == 0);
      we0 = ($urandom_range(1, 0) == 1); addr0 = 32'($urandom_range(255, 0)); wdata0 = $urandom;
      we1 = ($urandom_range(1, 0) == 1); addr1 = 32'($urandom_range(255, 0)); wdata1 = $urandom;
      if (!act) begin
        if (req0 || req1) begin
          act = 1'b1;
          t0 = cyc;
          if (req0 && req1) begin
            mport = ~last;
            last = mport;
          end else mport = req1;
          mwe  = mport ? we1 : we0;
          ma_h = mport ? addr1 : addr0;
          mw_h = mport ? wdata1 : wdata0;
        end
      end else if (ph == lat + 2) begin
        act = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) devmem[i] = 32'(i);

    // Reset mid-transaction on the LAT=2 instance.
    sel = 1'b0;
    do_reset();
    req0 = 1'b1; addr0 = 32'h10;
    tick();
    chk("rst_pre_busy", 128'({o_en, o_busy, o_gnt}), 128'({1'b1, 1'b1, 2'b01}));
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    chk("reset_state", 128'(obs_vec), 128'(0));
    tick();
    tick();
    reset = 1'b0;
    en_cyc = -1000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_no_ack", 128'({o_ack0, o_ack1, o_busy}), 128'(0));
    end
    req0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("rst_new_ack_c%0d", k), 128'(o_ack0), 128'(k == 4));
      if (k == 4) req0 = 1'b0;
    end

    // Port 0 read, LAT=2.
    devmem[8'h10] = 32'hDEADBEEF;
    do_reset();
    tab.delete();
    tab.push_back(row(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h00, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 32'h10, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 32'h10, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 32'h10, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 2'b01, 1, 0, 0, 32'h10, 0, 32'hDEADBEEF));
    tab.push_back(row(0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h10, 0, 32'hDEADBEEF));
    run_tab("rd_lat2");

    // Read then port 1 write, LAT=1: the write must leave rdata alone.
    sel = 1'b1;
    devmem[8'h30] = 32'h12345678;
    do_reset();
    tab.delete();
    tab.push_back(row(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h00, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 32'h30, 0, 32'h0));
    tab.push_back(row(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 32'h30, 0, 32'h0));
    tab.push_back(row(0, 0, 32'h30, 0, 1, 1, 32'h20, 32'hCAFE0001, 1, 0, 2'b01, 1, 0, 0, 32'h30, 0, 32'h12345678));
    tab.push_back(row(0, 0, 32'h30, 0, 1, 1, 32'h20, 32'hCAFE0001, 0, 0, 2'b00, 0, 0, 0, 32'h30, 0, 32'h12345678));
    tab.push_back(row(0, 0, 32'h30, 0, 1, 1, 32'h20, 32'hCAFE0001, 0, 0, 2'b10, 1, 1, 1, 32'h20, 32'hCAFE0001, 32'h12345678));
    tab.push_back(row(0, 0, 32'h30, 0, 1, 1, 32'h20, 32'hCAFE0001, 0, 0, 2'b10, 1, 0, 1, 32'h20, 32'hCAFE0001, 32'h12345678));
    tab.push_back(row(0, 0, 32'h30, 0, 0, 0, 32'h20, 32'hCAFE0001, 0, 1, 2'b10, 1, 0, 1, 32'h20, 32'hCAFE0001, 32'h12345678));
    tab.push_back(row(0, 0, 32'h30, 0, 0, 0, 32'h20, 32'hCAFE0001, 0, 0, 2'b00, 0, 0, 0, 32'h20, 32'hCAFE0001, 32'h12345678));
    run_tab("rdwr_lat1");
    chk("wr_landed", 128'(devmem[8'h20]), 128'(32'hCAFE0001));

    // Tie from reset, both held, LAT=1: 0,1,0,1 with 4-cycle transactions.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] eg;
      tick();
      eg = (k % 4 == 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("tie_c%0d", k), 128'({o_ack0, o_ack1, o_en, o_gnt}),
          128'({k % 8 == 3, k % 8 == 7, k % 4 == 1, eg}));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick(); tick();

    // Address change after the grant edge is ignored, LAT=2.
    sel = 1'b0;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("hold_addr_c%0d", k), 128'({o_addr, o_gnt, o_ack0}), 128'({32'h10, 2'b01, k == 4}));
      if (k == 1) addr0 = 32'h99;
      if (k == 4) req0 = 1'b0;
    end

    // Single requester held across back-to-back accesses, LAT=1.
    sel = 1'b1;
    do_reset();
    req0 = 1'b1; addr0 = 32'h40;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("b2b_c%0d", k), 128'({o_en, o_gnt[1], o_ack0}), 128'({k % 4 == 1, 1'b0, k % 4 == 3}));
    end
    req0 = 1'b0;

    sel = 1'b0;
    rand_run(400, "rand_lat2");
    sel = 1'b1;
    rand_run(400, "rand_lat1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
